// File: rtl/alu_sweep_checker.sv
// rtl/alu_sweep_checker.sv - on-board self-checking sweep sequencer for the ALU lab block
//
// Purpose:
//   Steps ALU_OP/AB_SW through all 64 combinations, with AB_SW as the outer loop.
//   Each vector is held for SETTLE_CYCLES cycles so the ALU outputs can settle.
//   F_in/OF_in/ZF_in are then sampled for one CHECK cycle and compared with a
//   built-in golden model. The result is reported as pass/done, an error count
//   and the first failing vector.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             level; begins a sweep from IDLE or DONE, ignored while busy
//   ALU_OP, AB_SW     vector driven to the ALU under test
//   F_in, OF_in, ZF_in ALU result and flags, sampled only in CHECK
//   busy, done, pass  sweep status (done/pass held until next start or rst)
//   err_count         number of mismatching vectors, 0..64
//   fail_valid, fail_op, fail_sw   first mismatching vector

module alu_sweep_checker #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [2:0]       ALU_OP,
   output logic [2:0]       AB_SW,
   input  logic [WIDTH-1:0] F_in,
   input  logic             OF_in,
   input  logic             ZF_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [6:0]       err_count,
   output logic             fail_valid,
   output logic [2:0]       fail_op,
   output logic [2:0]       fail_sw
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Counter runs SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES cycles in SETTLE.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS  = ~MSB_ONLY;

   state_t     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [6:0] err_q, err_d;
   logic       fv_q, fv_d;
   logic [2:0] fop_q, fop_d;
   logic [2:0] fsw_q, fsw_d;

   logic [WIDTH-1:0] gold_a, gold_b, gold_f, gold_sum, gold_diff;
   logic             gold_of, gold_zf, mismatch;

   // Golden operand table, indexed by AB_SW.
   always_comb begin
      gold_a = '0;
      gold_b = '0;
      case (idx_q[5:3])
         3'd0: begin gold_a = '0;                     gold_b = '0;                     end
         3'd1: begin gold_a = WIDTH'(32'h0000_0003);  gold_b = WIDTH'(32'h0000_0607);  end
         3'd2: begin gold_a = MSB_ONLY;               gold_b = MSB_ONLY;               end
         3'd3: begin gold_a = MAX_POS;                gold_b = WIDTH'(32'h0000_0001);  end
         3'd4: begin gold_a = ALL_ONES;               gold_b = ALL_ONES;               end
         3'd5: begin gold_a = MSB_ONLY;               gold_b = ALL_ONES;               end
         3'd6: begin gold_a = ALL_ONES;               gold_b = MSB_ONLY;               end
         default: begin gold_a = WIDTH'(32'h1234_5678); gold_b = WIDTH'(32'h3333_3333); end
      endcase
   end

   // Golden result and flags, indexed by ALU_OP.
   always_comb begin
      gold_sum  = gold_a + gold_b;
      gold_diff = gold_a - gold_b;
      gold_f    = '0;
      gold_of   = 1'b0;
      case (idx_q[2:0])
         3'd0: gold_f = gold_a & gold_b;
         3'd1: gold_f = gold_a | gold_b;
         3'd2: gold_f = gold_a ^ gold_b;
         3'd3: gold_f = ~(gold_a | gold_b);
         3'd4: begin
            gold_f  = gold_sum;
            // Same-sign operands producing a result of the other sign.
            gold_of = (gold_a[WIDTH-1] == gold_b[WIDTH-1]) &&
                      (gold_sum[WIDTH-1] != gold_a[WIDTH-1]);
         end
         3'd5: begin
            gold_f  = gold_diff;
            // Opposite-sign operands where the result sign differs from A.
            gold_of = (gold_a[WIDTH-1] != gold_b[WIDTH-1]) &&
                      (gold_diff[WIDTH-1] != gold_a[WIDTH-1]);
         end
         3'd6: gold_f = {{(WIDTH-1){1'b0}}, ($signed(gold_a) < $signed(gold_b))};
         default: gold_f = gold_b << gold_a[4:0];
      endcase
      gold_zf  = (gold_f == '0);
      mismatch = (F_in != gold_f) || (OF_in != gold_of) || (ZF_in != gold_zf);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fop_d   = fop_q;
      fsw_d   = fsw_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = SETTLE_LOAD;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               fv_d    = 1'b0;
               fop_d   = '0;
               fsw_d   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               // 64 vectors cap the count at 64; the guard keeps it from wrapping.
               if (err_q != 7'd64) begin
                  err_d = err_q + 7'd1;
               end
               if (!fv_q) begin
                  fv_d  = 1'b1;
                  fop_d = idx_q[2:0];
                  fsw_d = idx_q[5:3];
               end
            end
            if (idx_q == 6'd63) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_q == 7'd0) && !mismatch;
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + 6'd1;
               cnt_d   = SETTLE_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fop_q   <= '0;
         fsw_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fop_q   <= fop_d;
         fsw_q   <= fsw_d;
      end
   end

   assign ALU_OP     = idx_q[2:0];
   assign AB_SW      = idx_q[5:3];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_op    = fop_q;
   assign fail_sw    = fsw_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// tb/tb_alu_sweep_checker.sv - self-checking bench for alu_sweep_checker

module tb_alu_sweep_checker;

   localparam int WIDTH  = 32;
   localparam int SETTLE = 2;
   localparam int PERIOD = SETTLE + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [2:0]       ALU_OP, AB_SW;
   logic [WIDTH-1:0] F_in;
   logic             OF_in, ZF_in;
   logic             busy, done, pass;
   logic [6:0]       err_count;
   logic             fail_valid;
   logic [2:0]       fail_op, fail_sw;

   int errors = 0;
   int checks = 0;

   // 0 correct ALU, 1 OF stuck at 0, 2 F[0] flipped at op5/sw3, 3 random per-vector faults
   int         fault_mode = 0;
   logic       glitch_en  = 1'b0;
   logic [63:0] fault_mask = '0;
   logic [1:0] fault_kind [64];
   logic [5:0] prev_vec = '0;
   logic [5:0] vec;
   logic [33:0] ref_r;

   alu_sweep_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start),
      .ALU_OP(ALU_OP), .AB_SW(AB_SW),
      .F_in(F_in), .OF_in(OF_in), .ZF_in(ZF_in),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid),
      .fail_op(fail_op), .fail_sw(fail_sw)
   );

   always #5 clk = ~clk;

   // Reference ALU using wide signed integer arithmetic; returns {F, OF, ZF}.
   function automatic logic [33:0] alu_ref(input logic [2:0] op, input logic [2:0] sw);
      logic [31:0] a, b, f;
      logic        of;
      longint      s;
      case (sw)
         3'd0: begin a = 32'h0;         b = 32'h0;         end
         3'd1: begin a = 32'h00000003;  b = 32'h00000607;  end
         3'd2: begin a = 32'h80000000;  b = 32'h80000000;  end
         3'd3: begin a = 32'h7FFFFFFF;  b = 32'h00000001;  end
         3'd4: begin a = 32'hFFFFFFFF;  b = 32'hFFFFFFFF;  end
         3'd5: begin a = 32'h80000000;  b = 32'hFFFFFFFF;  end
         3'd6: begin a = 32'hFFFFFFFF;  b = 32'h80000000;  end
         default: begin a = 32'h12345678; b = 32'h33333333; end
      endcase
      of = 1'b0;
      s  = 0;
      case (op)
         3'd0: f = a & b;
         3'd1: f = a | b;
         3'd2: f = a ^ b;
         3'd3: f = ~(a | b);
         3'd4: begin
            s  = longint'($signed(a)) + longint'($signed(b));
            f  = a + b;
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd5: begin
            s  = longint'($signed(a)) - longint'($signed(b));
            f  = a - b;
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd6: f = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
         default: f = b << a[4:0];
      endcase
      return {f, of, (f == 32'd0)};
   endfunction

   assign vec = {AB_SW, ALU_OP};

   always @(posedge clk) prev_vec <= vec;

   // ALU stub: reference model plus the selected fault, plus optional garbage
   // on the first cycle after each vector change (well before the sample point).
   always_comb begin
      ref_r = alu_ref(ALU_OP, AB_SW);
      F_in  = ref_r[33:2];
      OF_in = ref_r[1];
      ZF_in = ref_r[0];
      case (fault_mode)
         1: OF_in = 1'b0;
         2: if (ALU_OP == 3'd5 && AB_SW == 3'd3) F_in[0] = ~F_in[0];
         3: if (fault_mask[vec]) begin
               case (fault_kind[vec])
                  2'd0: F_in  = F_in ^ 32'h1;
                  2'd1: F_in  = F_in ^ 32'h80000000;
                  2'd2: OF_in = ~OF_in;
                  default: ZF_in = ~ZF_in;
               endcase
            end
         default: ;
      endcase
      if (glitch_en && vec != prev_vec) begin
         F_in  = ~F_in;
         OF_in = ~OF_in;
         ZF_in = ~ZF_in;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse start and count cycles with busy high until done; bounded.
   task automatic run_sweep(output int cyc);
      int guard;
      cyc = 0;
      guard = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && guard < 2000) begin
         if (busy) cyc++;
         @(negedge clk);
         guard++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL sweep_timeout: done=%0b after %0d cycles, required 1", done, guard);
      end
   endtask

   task automatic check_report(input string name, input int exp_err, input logic exp_fv,
                               input logic [2:0] exp_op, input logic [2:0] exp_sw);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL %s.done: got %0b want 1", name, done); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s.busy: got %0b want 0", name, busy); end
      checks++;
      if (err_count !== 7'(exp_err)) begin errors++; $display("FAIL %s.err_count: got %0d want %0d", name, err_count, exp_err); end
      checks++;
      if (pass !== (exp_err == 0)) begin errors++; $display("FAIL %s.pass: got %0b want %0b", name, pass, exp_err == 0); end
      checks++;
      if (fail_valid !== exp_fv) begin errors++; $display("FAIL %s.fail_valid: got %0b want %0b", name, fail_valid, exp_fv); end
      if (exp_fv) begin
         checks++;
         if (fail_op !== exp_op || fail_sw !== exp_sw) begin
            errors++;
            $display("FAIL %s.first_fail: got op=%0d sw=%0d want op=%0d sw=%0d", name, fail_op, fail_sw, exp_op, exp_sw);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ALU_OP, AB_SW, busy, done, pass, err_count, fail_valid, fail_op, fail_sw} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got op=%0d sw=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0b fop=%0d fsw=%0d want all 0",
                  ALU_OP, AB_SW, busy, done, pass, err_count, fail_valid, fail_op, fail_sw);
      end
   endtask

   task automatic test_clean_sweep();
      int cyc;
      fault_mode = 0;
      run_sweep(cyc);
      checks++;
      if (cyc != 64 * PERIOD) begin errors++; $display("FAIL clean.busy_cycles: got %0d want %0d", cyc, 64 * PERIOD); end
      check_report("clean", 0, 1'b0, 3'd0, 3'd0);
      repeat (5) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clean.done_held: got done=%0b busy=%0b want 1/0", done, busy); end
   endtask

   task automatic test_of_stuck();
      int cyc;
      fault_mode = 1;
      run_sweep(cyc);
      check_report("of_stuck", 4, 1'b1, 3'd4, 3'd2);
      fault_mode = 0;
   endtask

   task automatic test_f_flip();
      int cyc;
      fault_mode = 2;
      run_sweep(cyc);
      check_report("f_flip", 1, 1'b1, 3'd5, 3'd3);
      fault_mode = 0;
   endtask

   task automatic test_mid_reset();
      int cyc;
      fault_mode = 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ALU_OP, AB_SW, busy, done, pass, err_count, fail_valid, fail_op, fail_sw} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got op=%0d sw=%0d busy=%0b done=%0b err=%0d fv=%0b want all 0",
                  ALU_OP, AB_SW, busy, done, err_count, fail_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ALU_OP !== 3'd0 || AB_SW !== 3'd0) begin
         errors++;
         $display("FAIL mid_reset_idle: got busy=%0b op=%0d sw=%0d want 0/0/0", busy, ALU_OP, AB_SW);
      end
      fault_mode = 0;
      run_sweep(cyc);
      checks++;
      if (cyc != 64 * PERIOD) begin errors++; $display("FAIL mid_reset.busy_cycles: got %0d want %0d", cyc, 64 * PERIOD); end
      check_report("after_reset", 0, 1'b0, 3'd0, 3'd0);
   endtask

   task automatic test_start_held();
      int guard;
      int cyc;
      fault_mode = 1;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      guard = 0;
      @(negedge clk);
      while (!done && guard < 2000) begin
         if (busy) cyc++;
         @(negedge clk);
         guard++;
      end
      checks++;
      if (cyc != 64 * PERIOD || !done) begin
         errors++;
         $display("FAIL held.no_restart: got busy_cycles=%0d done=%0b want %0d/1", cyc, done, 64 * PERIOD);
      end
      checks++;
      if (err_count !== 7'd4) begin errors++; $display("FAIL held.err_count: got %0d want 4", err_count); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || err_count !== 7'd0 || fail_valid !== 1'b0) begin
         errors++;
         $display("FAIL held.restart: got busy=%0b done=%0b err=%0d fv=%0b want 1/0/0/0", busy, done, err_count, fail_valid);
      end
      start = 1'b0;
      fault_mode = 0;
      do_reset();
   endtask

   task automatic test_sequence();
      logic [5:0] exp_vec;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 64 * PERIOD; k++) begin
         exp_vec = 6'(k / PERIOD);
         checks++;
         if (vec !== exp_vec || busy !== 1'b1) begin
            errors++;
            $display("FAIL sequence[%0d]: got sw=%0d op=%0d busy=%0b want sw=%0d op=%0d busy=1",
                     k, AB_SW, ALU_OP, busy, exp_vec[5:3], exp_vec[2:0]);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL sequence.end: got done=%0b busy=%0b want 1/0", done, busy);
      end
   endtask

   task automatic test_random_faults();
      int cyc;
      int exp_err;
      int first;
      fault_mode = 3;
      glitch_en  = 1'b1;
      for (int it = 0; it < 6; it++) begin
         case (it)
            0: fault_mask = '0;
            1: fault_mask = 64'h8000_0000_0000_0000;
            2: fault_mask = '1;
            default: fault_mask = {$urandom & $urandom & $urandom, $urandom & $urandom};
         endcase
         for (int i = 0; i < 64; i++) fault_kind[i] = 2'($urandom_range(0, 3));
         exp_err = 0;
         first   = -1;
         for (int i = 0; i < 64; i++) begin
            if (fault_mask[i]) begin
               exp_err++;
               if (first < 0) first = i;
            end
         end
         run_sweep(cyc);
         check_report($sformatf("random%0d", it), exp_err, first >= 0,
                      3'(first < 0 ? 0 : first % 8), 3'(first < 0 ? 0 : first / 8));
      end
      glitch_en  = 1'b0;
      fault_mode = 0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 64; i++) fault_kind[i] = 2'd0;
      test_reset();
      test_clean_sweep();
      test_of_stuck();
      test_f_flip();
      test_mid_reset();
      test_start_held();
      test_sequence();
      test_random_faults();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
